// File: rtl/regfile_writeback_queue_if.sv
// ============================================================================
// Module   : regfile_writeback_queue_if
// Purpose  : Producer handshake and register-file write-port bundle for the
//            write-back queue. slave = queue side, master = environment side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_writeback_queue_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_W-1:0]     in_addr;
   logic [DATA_W-1:0]     in_data;
   logic                  hold;
   logic [ADDR_W-1:0]     C;
   logic                  write;
   logic [DATA_W-1:0]     inputReg;
   logic [2**ADDR_W-1:0]  pending_mask;
   logic [CNT_W-1:0]      count;

   modport slave (
      input  in_valid, in_addr, in_data, hold,
      output in_ready, C, write, inputReg, pending_mask, count
   );

   modport master (
      output in_valid, in_addr, in_data, hold,
      input  in_ready, C, write, inputReg, pending_mask, count
   );
endinterface

`default_nettype wire

// File: rtl/regfile_writeback_queue.sv
// ============================================================================
// Module   : regfile_writeback_queue
// Purpose  : Small FIFO between ALU/memory results and the register file
//            write port. Drains one entry per cycle unless hold is high and
//            publishes a mask of registers with a write still in flight.
// Options  : WB_COALESCE_EN - merge a result into the newest queued entry
//            when it targets the same register (never the head entry).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback_queue #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
) (
   input  wire logic                   clk,
   input  wire logic                   reset,
   regfile_writeback_queue_if.slave    bus
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int MASK_W = 2**ADDR_W;

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_last_addr;
   logic [DATA_W-1:0] r_last_data;

   logic              w_not_empty;
   logic              w_not_full;
   logic              w_push;
   logic              w_pop;
   logic              w_coal;
   logic [PTR_W-1:0]  w_tail_m1;
   logic [DEPTH-1:0]  w_occ;
   logic [MASK_W-1:0] w_mask;

   assign w_not_empty = (r_count != '0);
   assign w_not_full  = (r_count < CNT_W'(DEPTH));
   assign w_tail_m1   = r_tail - PTR_W'(1);

`ifdef WB_COALESCE_EN
   // With two or more entries the newest one is never the head, so it is
   // safe to rewrite its data even while the head is being committed.
   assign w_coal = bus.in_valid && (r_count >= CNT_W'(2)) &&
                   (bus.in_addr == r_addr[w_tail_m1]);
`else
   assign w_coal = 1'b0;
`endif

   assign w_push = bus.in_valid && w_not_full && !w_coal;
   assign w_pop  = w_not_empty && !bus.hold;

   // in_ready is forced low while reset is asserted.
   assign bus.in_ready = reset && (w_not_full || w_coal);
   assign bus.write    = w_pop;
   assign bus.C        = w_not_empty ? r_addr[r_head] : r_last_addr;
   assign bus.inputReg = w_not_empty ? r_data[r_head] : r_last_data;
   assign bus.count    = r_count;

   // An entry is occupied if its distance from head is below count.
   for (genvar g = 0; g < DEPTH; g++) begin : g_occ
      logic [PTR_W-1:0] w_off;
      assign w_off    = PTR_W'(g) - r_head;
      assign w_occ[g] = ({1'b0, w_off} < r_count);
   end

   // Pending mask: OR of one-hot destination decodes of occupied entries.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_occ[i]) begin
            w_mask[r_addr[i]] = 1'b1;
         end
      end
   end

   assign bus.pending_mask = w_mask;

   // Queue storage, pointers, occupancy and last-presented head values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_last_addr <= '0;
         r_last_data <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_addr[r_tail] <= bus.in_addr;
            r_data[r_tail] <= bus.in_data;
            r_tail         <= r_tail + PTR_W'(1);
         end
         if (w_coal) begin
            r_data[w_tail_m1] <= bus.in_data;
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         // Remember what was on C/inputReg so they hold once the queue empties.
         if (w_not_empty) begin
            r_last_addr <= r_addr[r_head];
            r_last_data <= r_data[r_head];
         end
      end
   end
endmodule

`default_nettype wire
